// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master to one-slave memory arbiter with a zero-latency idle path and a one-deep replay buffer.
// Define MEM_ARBITER_RR_EN for round-robin on simultaneous strobes; fixed m0 priority otherwise.
module mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] m0_a,
    input  logic [31:0] m0_d,
    input  logic        m0_we,
    input  logic        m0_rd,
    output logic [31:0] m0_spo,
    output logic        m0_ready,
    input  logic [31:0] m1_a,
    input  logic [31:0] m1_d,
    input  logic        m1_we,
    input  logic        m1_rd,
    output logic [31:0] m1_spo,
    output logic        m1_ready,
    output logic [31:0] s_a,
    output logic [31:0] s_d,
    output logic        s_we,
    output logic        s_rd,
    input  logic [31:0] s_spo,
    input  logic        s_ready
);
    typedef enum logic [1:0] {IDLE, WAIT, ISSUE} state_t;
    state_t state, nxt;
    logic owner, own_we, pend_v, pend_m, pend_we, pend_rd;
    logic [31:0] own_a, pend_a, pend_d, hold0, hold1;
    logic st0, st1, win, g, act_v, act_m, act_rd, lat, lat_m, blk0, blk1, start_wait;
`ifdef MEM_ARBITER_RR_EN
    logic ptr;
    assign win = ~ptr;
`else
    assign win = 1'b0;
`endif
    assign st0 = m0_rd | m0_we;
    assign st1 = m1_rd | m1_we;
    assign g = (st0 && st1) ? win : st1;
    assign start_wait = (nxt == WAIT) && (state != WAIT);
    // act_* describes the transfer currently talking to the slave; lat captures a strobe into the replay buffer.
    always_comb begin
        nxt = state;
        s_a = m0_a;
        s_d = m0_d;
        s_rd = 1'b0;
        s_we = 1'b0;
        act_v = 1'b0;
        act_m = 1'b0;
        act_rd = 1'b0;
        lat = 1'b0;
        lat_m = 1'b0;
        case (state)
            IDLE: begin
                if (pend_v) nxt = ISSUE;
                else if (st0 || st1) begin
                    act_v = 1'b1;
                    act_m = g;
                    act_rd = g ? m1_rd : m0_rd;
                    s_a = g ? m1_a : m0_a;
                    s_d = g ? m1_d : m0_d;
                    s_rd = act_rd;
                    s_we = g ? m1_we : m0_we;
                    lat = st0 && st1;
                    lat_m = ~g;
                    nxt = s_ready ? IDLE : WAIT;
                end
            end
            WAIT: begin
                act_v = 1'b1;
                act_m = owner;
                act_rd = ~own_we;
                s_a = own_a;
                lat = !pend_v && (owner ? st0 : st1);
                lat_m = ~owner;
                nxt = s_ready ? IDLE : WAIT;
            end
            ISSUE: begin
                act_v = 1'b1;
                act_m = pend_m;
                act_rd = pend_rd;
                s_a = pend_a;
                s_d = pend_d;
                s_rd = pend_rd;
                s_we = pend_we;
                lat = pend_m ? st0 : st1;
                lat_m = ~pend_m;
                nxt = s_ready ? IDLE : WAIT;
            end
            default: nxt = IDLE;
        endcase
        if (rst) begin
            s_rd = 1'b0;
            s_we = 1'b0;
        end
    end
    assign blk0 = (pend_v && !pend_m && state != ISSUE) || (lat && !lat_m);
    assign blk1 = (pend_v && pend_m && state != ISSUE) || (lat && lat_m);
    assign m0_ready = rst || ((act_v && !act_m) ? s_ready : !blk0);
    assign m1_ready = rst || ((act_v && act_m) ? s_ready : !blk1);
    assign m0_spo = (act_v && !act_m && act_rd && s_ready) ? s_spo : hold0;
    assign m1_spo = (act_v && act_m && act_rd && s_ready) ? s_spo : hold1;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pend_v <= 1'b0;
            owner <= 1'b0;
            hold0 <= '0;
            hold1 <= '0;
        end else begin
            state <= nxt;
            if (state == ISSUE) pend_v <= 1'b0;
            if (lat) pend_v <= 1'b1;
            if (start_wait) owner <= act_m;
            if (act_v && act_rd && s_ready && !act_m) hold0 <= s_spo;
            if (act_v && act_rd && s_ready && act_m) hold1 <= s_spo;
        end
    end
    always_ff @(posedge clk) begin
        if (lat) begin
            pend_m <= lat_m;
            pend_a <= lat_m ? m1_a : m0_a;
            pend_d <= lat_m ? m1_d : m0_d;
            pend_we <= lat_m ? m1_we : m0_we;
            pend_rd <= lat_m ? m1_rd : m0_rd;
        end
        if (start_wait) begin
            own_a <= s_a;
            own_we <= s_we;
        end
    end
`ifdef MEM_ARBITER_RR_EN
    always_ff @(posedge clk) begin
        if (rst) ptr <= 1'b0;
        else if (act_v && state == IDLE) ptr <= act_m;
    end
`endif
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; rst  in  1  synchronous active-high reset.
REQ-002 SHALL have master 0 (CPU, primary) ports: m0_a in 32, m0_d in 32, m0_we in 1, m0_rd in 1, m0_spo out 32, m0_ready out 1.
REQ-003 SHALL have master 1 (DMA/loader) ports: m1_a, m1_d, m1_we, m1_rd, m1_spo, m1_ready, with the same widths and directions as master 0.
REQ-004 SHALL have slave-side ports: s_a out 32, s_d out 32, s_we out 1, s_rd out 1, s_spo in 32, s_ready in 1.
REQ-005 SHALL use one clock with synchronous active-high reset; all state changes on posedge clk.

Function
REQ-006 Bus protocol: a request is mN_rd or mN_we high for exactly one cycle. mN_ready is the level completion flag and is high when the master has nothing outstanding. mN_spo is valid in every cycle that mN_ready is high after a read.
REQ-007 Three states: IDLE, WAIT(owner), ISSUE(pending master).
REQ-008 IDLE, no pending, single strobe from master N: slave outputs are muxed combinationally from master N; mN_ready = s_ready and mN_spo = s_spo in the same cycle. This adds zero latency. If s_ready = 1, stay in IDLE; otherwise latch the owner (a, we) and go to WAIT.
REQ-009 IDLE, simultaneous strobes: the winner takes the REQ-008 path. The loser's a, d, we and rd are latched into the pending buffer, and the loser's ready is driven low combinationally in that cycle.
REQ-010 WAIT: s_a is held at the owner's latched address and s_rd = s_we = 0. Owner: ready = s_ready, spo = s_spo. Return to IDLE on s_ready = 1.
REQ-011 A strobe from the non-owner during WAIT or ISSUE is latched into pending; that master's ready goes low the same cycle and stays low until its replay completes.
REQ-012 IDLE with pending valid: go to ISSUE; any new strobe that cycle is ignored (protocol allows none, since only the other master can be ready).
REQ-013 ISSUE: drive the latched a, d, we and rd onto the slave for one cycle. If s_ready = 1, the pending master gets ready = 1 and spo = s_spo, pending clears, and the state goes to IDLE. Otherwise set owner = pending master, clear pending, and go to WAIT.
REQ-014 Non-owner with nothing outstanding: ready = 1, spo = last value captured for that master (per-master 32-bit hold register).
REQ-015 Pending buffer depth is 1. A strobe from a master whose ready is low is a protocol violation and is ignored.
REQ-016 When idle, s_rd = s_we = 0 and s_a/s_d carry m0 values (pass-through default).
REQ-017 Arbitration applies only to simultaneous strobes in IDLE; a pending replay always precedes new work.

Reset
REQ-018 On rst: state = IDLE; pending cleared; owner = 0; hold registers = 0; round-robin pointer = 0.
REQ-019 While rst is high: m0_ready = m1_ready = 1 and s_rd = s_we = 0.
REQ-020 Reset during WAIT or ISSUE abandons the transfer; nothing is replayed after reset.

Configuration
REQ-021 Macro MEM_ARBITER_RR_EN defined: simultaneous strobes are granted round-robin. The 1-bit last-grant pointer flips to the granted master on every IDLE grant, and the master not last granted wins.
REQ-022 Macro MEM_ARBITER_RR_EN undefined: master 0 always wins simultaneous strobes, and the pointer logic is absent.

Verification
REQ-023 m0_rd, a=0x100, s_ready=1, s_spo=0xDEADBEEF -> same cycle: s_rd=1, s_a=0x100, m0_ready=1, m0_spo=0xDEADBEEF; state stays IDLE.
REQ-024 m0_rd, a=0x200, with s_ready low for 3 cycles -> m0_ready=0 for 3 cycles; s_a=0x200 held, s_rd=0 after the first cycle; m0_ready=1 with data in the 4th cycle.
REQ-025 Simultaneous m0_we (a=0x10, d=0x1) and m1_rd (a=0x20), s_ready=1 constant, fixed priority -> cycle 0: m0 write, m1_ready=0; cycle 1: IDLE->ISSUE; cycle 2: s_rd=1, s_a=0x20, m1_ready=1.
REQ-026 Same stimulus as REQ-025 repeated twice with MEM_ARBITER_RR_EN -> first pair won by m1 (pointer 0), second pair won by m0.
REQ-027 m1_rd during m0 WAIT, then rst asserted -> next cycle both readies=1, s_rd=0, no replay of the m1 request.
REQ-028 Read by m1 completes with 0x5A5A5A5A, then 10 cycles of m0 traffic -> m1_spo stays 0x5A5A5A5A and m1_ready stays 1.
